// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the response consumer and the shared Alu.
// Ports: req0_*/req1_* requests, rsp_* response, alu_* Alu drive/return, busy.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_zero;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero;

    logic             busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_err,
        input  rsp_ready,
        output alu_x, alu_y, alu_op,
        input  alu_r, alu_zero,
        output busy
    );

    // Requesters, response consumer and Alu side.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_err,
        output rsp_ready,
        input  alu_x, alu_y, alu_op,
        output alu_r, alu_zero,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational Alu between two requesters.
// Ports: clk, rst (sync, active high), bus (alu_arbiter_if.slave).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic last_grant;
    logic id;
    logic err;
    logic grant0;
    logic grant1;
    logic accept;
    logic sel;
    logic legal;

    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grants only exist in IDLE; on contention the requester that did not
    // win last time gets the Alu.
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
                grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
                if (grant0 || grant1) begin
                    state_nx = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.busy       = (state != IDLE);

    assign accept = grant0 || grant1;
    assign sel    = grant1;
    assign sel_op = sel ? bus.req1_op : bus.req0_op;
    assign sel_a  = sel ? bus.req1_a : bus.req0_a;
    assign sel_b  = sel ? bus.req1_b : bus.req0_b;

    always_comb begin
        case (sel_op)
            OPW'(0), OPW'(1), OPW'(2),
            OPW'(6), OPW'(7), OPW'(12): legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= 1'b1;
            id            <= 1'b0;
            err           <= 1'b0;
            bus.alu_x     <= '0;
            bus.alu_y     <= '0;
            bus.alu_op    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_r     <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id         <= sel;
                        last_grant <= sel;
                        err        <= !legal;
                        // Illegal ops never reach the Alu inputs.
                        if (legal) begin
                            bus.alu_x  <= sel_a;
                            bus.alu_y  <= sel_b;
                            bus.alu_op <= sel_op;
                        end
                    end
                end
                EXEC: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= id;
                    if (err) begin
                        bus.rsp_r    <= '0;
                        bus.rsp_zero <= 1'b1;
                        bus.rsp_err  <= 1'b1;
                    end else begin
                        bus.rsp_r    <= bus.alu_r;
                        bus.rsp_zero <= bus.alu_zero;
                        bus.rsp_err  <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
